// File: rtl/shared_reg_pkg.sv
// Shared definitions for the shared-register arbiter: command encodings and index-width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package shared_reg_pkg;

  // Per-requester command encoding carried on req_op
  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_PRESET = 2'b10;
  localparam logic [1:0] OP_NOP    = 2'b11;

  // Width of a requester index; never narrower than one bit
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: rotate the request vector by ptr, take the lowest set bit, rotate the index back.
// Latency: purely combinational, zero cycles.
// Backpressure: none; grant is all zero and any is low when no request is present.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] win,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             pos;
  int             sum;

  // Priority search starting at ptr, wrapping modulo N
  always_comb begin
    dbl = {req, req};
    rot = N'(dbl >> ptr);
    pos = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) pos = k;
    end
    sum = int'(ptr) + pos;
    if (sum >= N) sum = sum - N;
    win   = IW'(sum);
    any   = |req;
    grant = '0;
    if (any) grant[win] = 1'b1;
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter owning one shared WIDTH-bit register; requesters LOAD, CLEAR, PRESET or NOP it.
// Latency: accept to q visible is one cycle; one command accepted per cycle.
// Backpressure: combinational one-hot req_ready; losers retry. Optional lock: define SHARED_REG_LOCK_EN.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int               N_REQ      = 4,
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [WIDTH-1:0] PRESET_VAL = '1,
  localparam int              IW         = idx_w(N_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_data,
`ifdef SHARED_REG_LOCK_EN
  input  logic [N_REQ-1:0]       req_lock,
`endif
  output logic [N_REQ-1:0]       req_ready,
  output logic [WIDTH-1:0]       q,
  output logic [IW-1:0]          last_id,
  output logic                   upd
);

  logic [IW-1:0]    ptr;
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    win;
  logic             any;
  logic             xfer;
  logic [1:0]       op_w;
  logic [WIDTH-1:0] data_w;
  logic [IW-1:0]    next_ptr;

`ifdef SHARED_REG_LOCK_EN
  logic             lock_active;
  logic [IW-1:0]    lock_owner;

  // While locked only the owner is eligible; if it drops valid nobody is granted
  always_comb begin
    elig = req_valid;
    if (lock_active) elig = req_valid & (N_REQ'(1) << lock_owner);
  end
`else
  // Every valid requester competes
  always_comb begin
    elig = req_valid;
  end
`endif

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req   (elig),
    .ptr   (ptr),
    .grant (grant),
    .win   (win),
    .any   (any)
  );

  // Reset suppresses all grants, so no transfer can coincide with reset
  assign req_ready = reset ? '0 : grant;
  assign xfer      = any & ~reset;
  assign next_ptr  = (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);

  // Select the winning requester's op and data slices
  always_comb begin
    op_w   = OP_NOP;
    data_w = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IW'(i)) begin
        op_w   = req_op[2*i +: 2];
        data_w = req_data[WIDTH*i +: WIDTH];
      end
    end
  end

  // Register update, pointer rotation and (optional) lock tracking on each accept
  always_ff @(posedge clk) begin
    if (reset) begin
      q       <= RESET_VAL;
      last_id <= '0;
      upd     <= 1'b0;
      ptr     <= '0;
`ifdef SHARED_REG_LOCK_EN
      lock_active <= 1'b0;
      lock_owner  <= '0;
`endif
    end else begin
      upd <= 1'b0;
      if (xfer) begin
        last_id <= win;
        upd     <= (op_w != OP_NOP);
        case (op_w)
          OP_LOAD:   q <= data_w;
          OP_CLEAR:  q <= '0;
          OP_PRESET: q <= PRESET_VAL;
          default:   ;
        endcase
`ifdef SHARED_REG_LOCK_EN
        // A locking accept freezes the pointer; the releasing accept moves it past the owner
        lock_active <= req_lock[win];
        lock_owner  <= win;
        if (!req_lock[win]) ptr <= next_ptr;
`else
        ptr <= next_ptr;
`endif
      end
    end
  end

endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin scheduler that shares one WIDTH-bit storage register (clear/preset/load flop bank) among N_REQ requesters.
- Each requester issues a valid/ready command: load data, clear, or preset.
- Grants at most one command per cycle; the register updates on the following clock edge.
- Sits between client blocks and the shared register; it owns that register outright.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- WIDTH, 8, register width in bits
- RESET_VAL, 0, register value after reset
- PRESET_VAL, all ones, value written by a PRESET command

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  N_REQ  per-requester command valid
- req_op  input  2*N_REQ  per-requester op, slice i at [2i+1:2i]; encoding 00 LOAD, 01 CLEAR, 10 PRESET, 11 NOP
- req_data  input  WIDTH*N_REQ  per-requester load data, slice i at [WIDTH*i +: WIDTH]
- req_ready  output  N_REQ  one-hot accept, combinational
- q  output  WIDTH  shared register value
- last_id  output  clog2(N_REQ)  index of the last accepted requester
- upd  output  1  pulses 1 cycle after an accept, i.e. q changed this cycle

Behaviour:
- Reset (synchronous, on clk edge with reset=1):
  - q=RESET_VAL, last_id=0, upd=0.
  - Round-robin pointer ptr=0.
  - req_ready is all zero while reset=1.
- Arbitration, combinational each cycle:
  - Search req_valid starting at index ptr, wrapping modulo N_REQ.
  - The first set bit wins; req_ready = onehot(win).
  - No valid request: req_ready=0.
- Transfer occurs when req_valid[i] & req_ready[i] at the clock edge. On transfer:
  - q <= req_data slice for LOAD, 0 for CLEAR, PRESET_VAL for PRESET.
  - q is unchanged for NOP; NOP still consumes the grant and advances the pointer.
  - last_id <= win.
  - ptr <= (win+1) mod N_REQ.
  - upd <= 1 unless op=NOP.
- No transfer: q, ptr and last_id hold; upd <= 0.
- Latency: request to q visible is 1 cycle. Throughput: 1 command/cycle.
- Fairness: a continuously requesting client waits at most N_REQ-1 grants.
- Requesters must hold valid, op and data stable until ready. Dropping valid before ready is permitted; the arbiter re-evaluates each cycle with no memory of the dropped request.
- Wrap-around: win = N_REQ-1 sets ptr=0.
- Simultaneous requests: only one is accepted; the others see ready=0 and retry.
- Reset mid-operation: reset overrides any transfer in the same cycle, and no ready is issued.

Optional Feature:
- Macro: SHARED_REG_LOCK_EN.
- With the macro defined:
  - Adds input req_lock [N_REQ].
  - A transfer from requester i with req_lock[i]=1 sets lock_active=1 and lock_owner=i.
  - While lock_active, only lock_owner can be granted; ptr does not advance.
  - A transfer from the owner with req_lock=0 clears the lock, and ptr <= owner+1.
  - If the owner drops valid while locked, no grants are issued (stall).
  - Reset clears the lock.
- Without the macro:
  - No req_lock port and no lock state.
  - Pure round-robin as above.

Decomposition:
- Package shared_reg_pkg:
  - op encoding localparams OP_LOAD, OP_CLEAR, OP_PRESET, OP_NOP
  - helper function for the index width, clog2
- One sub-module, rr_pick:
  - Purely combinational rotate-priority-rotate-back picker.
  - Inputs: req vector and ptr. Outputs: one-hot grant, win index, any flag.
  - The top level holds all state: q, ptr, last_id, upd, lock.

Test Plan:
- Reset held 2 cycles with all valid high: req_ready=0 throughout; after release q=0x00, last_id=0, upd=0.
- Requester 2 alone, LOAD 0xA5: req_ready=0b0100 the same cycle; next cycle q=0xA5, upd=1, last_id=2.
- All 4 valid, LOAD of values 0x11..0x44, held: grants in order 0,1,2,3,0 on consecutive cycles; q follows one cycle behind.
- Requester 3 then requester 1 both valid with ptr=3: grant 3 (PRESET, q=0xFF), ptr wraps to 0, next grant 1 (CLEAR, q=0x00).
- Requester 0 NOP: granted, q unchanged, upd=0, ptr=1.
- With SHARED_REG_LOCK_EN: requester 1 LOAD 0x3C with lock=1 while 0 and 2 are valid. Only 1 is granted until it sends lock=0; the next grant goes to 2.
